// File: rtl/multi_channel_debouncer.sv
// Per-channel debouncer: optional input synchroniser, then a 4-state qualify FSM with
// a saturating run timer. Outputs are registered; rise_pulse/fall_pulse mark dout edges.
module multi_channel_debouncer #(
  parameter int CHANNELS    = 4,
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [CNT_W-1:0]    rise_thr,
  input  logic [CNT_W-1:0]    fall_thr,
  input  logic [CHANNELS-1:0] din,
  output logic [CHANNELS-1:0] dout,
  output logic [CHANNELS-1:0] rise_pulse,
  output logic [CHANNELS-1:0] fall_pulse
);

  typedef enum logic [1:0] {ZERO, PEND_RISE, ONE, PEND_FALL} state_t;

  localparam logic [CNT_W-1:0] T_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] T_MAX = '1;

  logic [CHANNELS-1:0] s;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign s = din;
    end else begin : g_sync
      logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
        end else begin
          sync_q[0] <= din;
          for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
      end
      assign s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // A zero threshold qualifies on the first matching sample, same as 1.
  logic [CNT_W-1:0] rise_eff, fall_eff;
  assign rise_eff = (rise_thr == '0) ? T_ONE : rise_thr;
  assign fall_eff = (fall_thr == '0) ? T_ONE : fall_thr;

  state_t              state_q [CHANNELS];
  state_t              state_d [CHANNELS];
  logic [CNT_W-1:0]    timer_q [CHANNELS];
  logic [CNT_W-1:0]    timer_d [CHANNELS];
  logic [CHANNELS-1:0] dout_d;

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      state_d[i] = state_q[i];
      timer_d[i] = timer_q[i];
      case (state_q[i])
        ZERO: begin
          if (en) begin
            if (s[i]) begin
              if (rise_eff == T_ONE) begin
                state_d[i] = ONE;
                timer_d[i] = '0;
              end else begin
                state_d[i] = PEND_RISE;
                timer_d[i] = T_ONE;
              end
            end else begin
              timer_d[i] = '0;
            end
          end
        end
        PEND_RISE: begin
          if (en) begin
            if (!s[i]) begin
              state_d[i] = ZERO;
              timer_d[i] = '0;
            end else if (({1'b0, timer_q[i]} + (CNT_W+1)'(1)) >= {1'b0, rise_eff}) begin
              state_d[i] = ONE;
              timer_d[i] = '0;
            end else begin
              timer_d[i] = (timer_q[i] == T_MAX) ? T_MAX : timer_q[i] + T_ONE;
            end
          end
        end
        ONE: begin
          if (en) begin
            if (!s[i]) begin
              if (fall_eff == T_ONE) begin
                state_d[i] = ZERO;
                timer_d[i] = '0;
              end else begin
                state_d[i] = PEND_FALL;
                timer_d[i] = T_ONE;
              end
            end else begin
              timer_d[i] = '0;
            end
          end
        end
        PEND_FALL: begin
          if (en) begin
            if (s[i]) begin
              state_d[i] = ONE;
              timer_d[i] = '0;
            end else if (({1'b0, timer_q[i]} + (CNT_W+1)'(1)) >= {1'b0, fall_eff}) begin
              state_d[i] = ZERO;
              timer_d[i] = '0;
            end else begin
              timer_d[i] = (timer_q[i] == T_MAX) ? T_MAX : timer_q[i] + T_ONE;
            end
          end
        end
        default: begin
          state_d[i] = ZERO;
          timer_d[i] = '0;
        end
      endcase
      dout_d[i] = (state_d[i] == ONE) || (state_d[i] == PEND_FALL);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i] <= ZERO;
        timer_q[i] <= '0;
      end
      dout       <= '0;
      rise_pulse <= '0;
      fall_pulse <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i] <= state_d[i];
        timer_q[i] <= timer_d[i];
      end
      // State only moves while en=1, so these edges are already gated by enable.
      dout       <= dout_d;
      rise_pulse <= dout_d & ~dout;
      fall_pulse <= ~dout_d & dout;
    end
  end

endmodule

// File: doc/multi_channel_debouncer.md
MULTI_CHANNEL_DEBOUNCER -- requirements
Module: multi_channel_debouncer

Interface
REQ-001 Parameter CHANNELS, default 4, number of independent debounce channels, legal range 1..32.
REQ-002 Parameter CNT_W, default 8, width of the per-channel timer and of the threshold inputs, legal range 2..16.
REQ-003 Parameter SYNC_STAGES, default 2, input synchroniser flops per channel; legal range 0..3, where 0 means no synchroniser.
REQ-004 Port clk, input, 1, the single clock; all logic SHALL be clocked on its rising edge.
REQ-005 Port rst, input, 1, reset; synchronous and active-high.
REQ-006 Port en, input, 1, global enable; low freezes all channel state.
REQ-007 Port rise_thr, input, CNT_W, number of consecutive high samples required to assert an output; shared by all channels.
REQ-008 Port fall_thr, input, CNT_W, number of consecutive low samples required to deassert an output; shared by all channels.
REQ-009 Port din, input, CHANNELS, raw bouncing inputs, one bit per channel.
REQ-010 Port dout, output, CHANNELS, registered debounced levels.
REQ-011 Port rise_pulse, output, CHANNELS, registered one-cycle strobe when dout[i] goes 0->1.
REQ-012 Port fall_pulse, output, CHANNELS, registered one-cycle strobe when dout[i] goes 1->0.

Function
REQ-013 Each channel SHALL run its own 4-state FSM (ZERO, PEND_RISE, ONE, PEND_FALL) and its own CNT_W-bit timer, with no interaction between channels.
REQ-014 The FSM and timer SHALL act on s[i], the synchronised din[i], delayed by SYNC_STAGES cycles.
REQ-015 In ZERO with s=1: the FSM SHALL go to ONE if the effective rise threshold is 1, else to PEND_RISE with timer=1; with s=0 it SHALL stay in ZERO with timer=0.
REQ-016 In PEND_RISE with s=1: the FSM SHALL go to ONE if timer+1 >= effective rise threshold, else increment the timer; with s=0 it SHALL return to ZERO with timer=0, and no pulse SHALL be produced.
REQ-017 ONE and PEND_FALL SHALL mirror REQ-015 and REQ-016 using s=0 and fall_thr.
REQ-018 The effective threshold SHALL be the threshold input value, except that a value of 0 SHALL be treated as 1.
REQ-019 dout[i] SHALL be 1 exactly when the FSM is in ONE or PEND_FALL.
REQ-020 Latency: N consecutive matching samples at threshold N SHALL flip dout on the edge that samples the Nth one; the total delay from the din edge is SYNC_STAGES+N cycles.
REQ-021 Threshold inputs SHALL be sampled every cycle; a threshold change during PEND SHALL apply immediately against the current timer value.
REQ-022 The timer SHALL never wrap; it SHALL saturate at 2^CNT_W-1, which is unreachable in practice because the transition fires first.
REQ-023 rise_pulse[i] SHALL be high for exactly the first cycle in which dout[i]=1; fall_pulse[i] SHALL be high for exactly the first cycle in which dout[i]=0 after being 1.
REQ-024 When en=0: FSM state, timers and dout SHALL hold, pulses SHALL be 0, and the synchroniser SHALL keep shifting.
REQ-025 Channels that qualify on the same edge SHALL each assert their own pulse in the same cycle.
REQ-026 An unreachable FSM state SHALL recover to ZERO on the next clock with dout=0 and no pulse.

Reset
REQ-027 While rst=1 at a rising edge, every FSM SHALL go to ZERO, and all timers, synchroniser flops, dout, rise_pulse and fall_pulse SHALL be 0.
REQ-028 Reset SHALL override en and any pending qualification, and no pulse SHALL be emitted as a result of reset.
REQ-029 After rst deasserts, qualification SHALL restart from count 0 on the first sampled edge.

Verification
REQ-030 Clean rise: SYNC_STAGES=2, rise_thr=3, din[0] steps 0->1 at cycle 0 -> dout[0]=1 from cycle 5, rise_pulse[0]=1 in cycle 5 only.
REQ-031 Glitch reject: rise_thr=4, din[1] high for 3 cycles then low -> dout[1] stays 0 and no pulse; a following 4-cycle high -> dout[1]=1.
REQ-032 Asymmetric thresholds: rise_thr=2, fall_thr=6, with a 1-cycle low dip while dout=1 -> dout remains 1; a 6-cycle low -> fall_pulse in the cycle dout drops.
REQ-033 Threshold 0 and 1 with SYNC_STAGES=0: din step -> dout follows 1 cycle later; rise_thr=0 behaves identically to rise_thr=1.
REQ-034 Enable freeze and reset: en=0 mid-PEND_RISE for 5 cycles -> timer holds, then resumes; rst=1 mid-PEND_RISE -> all outputs 0 next cycle and no pulse.
REQ-035 Independence: all CHANNELS toggling with different patterns against a per-channel reference model -> exact match, including simultaneous pulses on several channels.
